sad_min_scheduler: RTL and testbench

Sequencer that finds the minimum SAD and its motion-vector index over one search window. It accepts candidates from the VBSME PE array in beats of six SAD/index pairs and time-shares a single 6-to-3 pairwise compare stage across three reduction passes per beat. It keeps a running best across all beats and reports the winner to the motion-vector output logic with a one-cycle `done` pulse.

---
 rtl/vbsme_pkg.sv | 25 ++
 rtl/sad_pair_stage.sv | 39 +++
 rtl/sad_min_scheduler.sv | 202 ++++++++++++++++++++
 tb/tb_sad_min_scheduler.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vbsme_pkg.sv
// Shared definitions for the VBSME minimum-SAD search logic: default
// datapath widths, the all-ones SAD sentinel, scheduler states and the
// SAD/index candidate record.
package vbsme_pkg;

    localparam int SAD_W = 32;
    localparam int IDX_W = 32;

    localparam logic [SAD_W-1:0] SAD_MAX = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_R1,
        ST_R2,
        ST_R3,
        ST_DONE
    } sad_sched_state_t;

    typedef struct packed {
        logic [SAD_W-1:0] sad;
        logic [IDX_W-1:0] index;
    } sad_cand_t;

endpackage

// File: rtl/sad_pair_stage.sv
// Three independent 2-to-1 minimum selects on (sad, index) pairs.
// Slot a holds the earlier candidate, so b only wins when it is strictly
// smaller. A candidate with its valid bit clear never wins; the output
// valid tells the next reduction level whether anything real survived.
module sad_pair_stage
    import vbsme_pkg::*;
#(
    parameter int SAD_W = vbsme_pkg::SAD_W,
    parameter int IDX_W = vbsme_pkg::IDX_W
) (
    input  logic [2:0][SAD_W-1:0] a_sad,
    input  logic [2:0][IDX_W-1:0] a_index,
    input  logic [2:0]            a_valid,
    input  logic [2:0][SAD_W-1:0] b_sad,
    input  logic [2:0][IDX_W-1:0] b_index,
    input  logic [2:0]            b_valid,
    output logic [2:0][SAD_W-1:0] w_sad,
    output logic [2:0][IDX_W-1:0] w_index,
    output logic [2:0]            w_valid
);

    // Pick the winner of each pair, favouring slot a on equal SAD
    always_comb begin
        w_sad   = '0;
        w_index = '0;
        w_valid = '0;
        for (int i = 0; i < 3; i++) begin
            if (b_valid[i] && (!a_valid[i] || (b_sad[i] < a_sad[i]))) begin
                w_sad[i]   = b_sad[i];
                w_index[i] = b_index[i];
            end else begin
                w_sad[i]   = a_sad[i];
                w_index[i] = a_index[i];
            end
            w_valid[i] = a_valid[i] | b_valid[i];
        end
    end

endmodule

// File: rtl/sad_min_scheduler.sv
// Minimum-SAD scheduler for one search window. Each six-lane beat is folded
// into a running best over three passes through one shared pair stage.
// Optional feature: define SAD_LANE_MASK_EN to add the per-lane in_mask
// input; masked lanes are excluded from every comparison.
module sad_min_scheduler
    import vbsme_pkg::*;
#(
    parameter int SAD_W  = vbsme_pkg::SAD_W,
    parameter int IDX_W  = vbsme_pkg::IDX_W,
    parameter int BEAT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [BEAT_W-1:0]    cfg_beats,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [6*SAD_W-1:0]   in_sad,
    input  logic [6*IDX_W-1:0]   in_index,
`ifdef SAD_LANE_MASK_EN
    input  logic [5:0]           in_mask,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [SAD_W-1:0]     best_sad,
    output logic [IDX_W-1:0]     best_index
);

    sad_sched_state_t state;
    sad_sched_state_t next_state;

    logic [BEAT_W-1:0]       remaining;
    logic [5:0][SAD_W-1:0]   lane_sad;
    logic [5:0][IDX_W-1:0]   lane_index;
    logic [5:0]              lane_valid;
    logic [2:0][SAD_W-1:0]   win_sad;
    logic [2:0][IDX_W-1:0]   win_index;
    logic [2:0]              win_valid;

    logic [2:0][SAD_W-1:0]   a_sad;
    logic [2:0][IDX_W-1:0]   a_index;
    logic [2:0]              a_valid;
    logic [2:0][SAD_W-1:0]   b_sad;
    logic [2:0][IDX_W-1:0]   b_index;
    logic [2:0]              b_valid;
    logic [2:0][SAD_W-1:0]   w_sad;
    logic [2:0][IDX_W-1:0]   w_index;
    logic [2:0]              w_valid;

    logic [5:0]              beat_lane_valid;

`ifdef SAD_LANE_MASK_EN
    assign beat_lane_valid = ~in_mask;
`else
    assign beat_lane_valid = '1;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and handshake/status outputs
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    next_state = (cfg_beats == '0) ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    next_state = ST_R1;
                end
            end
            ST_R1:   next_state = ST_R2;
            ST_R2:   next_state = ST_R3;
            ST_R3:   next_state = (remaining > BEAT_W'(1)) ? ST_WAIT : ST_DONE;
            ST_DONE: begin
                done       = 1'b1;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Route operands into the shared stage for the current reduction pass
    always_comb begin
        a_sad   = '1;
        a_index = '0;
        a_valid = '0;
        b_sad   = '1;
        b_index = '0;
        b_valid = '0;
        case (state)
            ST_R1: begin
                for (int i = 0; i < 3; i++) begin
                    a_sad[i]   = lane_sad[2*i];
                    a_index[i] = lane_index[2*i];
                    a_valid[i] = lane_valid[2*i];
                    b_sad[i]   = lane_sad[2*i+1];
                    b_index[i] = lane_index[2*i+1];
                    b_valid[i] = lane_valid[2*i+1];
                end
            end
            ST_R2: begin
                a_sad[0]   = best_sad;
                a_index[0] = best_index;
                a_valid[0] = 1'b1;
                b_sad[0]   = win_sad[0];
                b_index[0] = win_index[0];
                b_valid[0] = win_valid[0];
                a_sad[1]   = win_sad[1];
                a_index[1] = win_index[1];
                a_valid[1] = win_valid[1];
                b_sad[1]   = win_sad[2];
                b_index[1] = win_index[2];
                b_valid[1] = win_valid[2];
            end
            ST_R3: begin
                a_sad[0]   = win_sad[0];
                a_index[0] = win_index[0];
                a_valid[0] = win_valid[0];
                b_sad[0]   = win_sad[1];
                b_index[0] = win_index[1];
                b_valid[0] = win_valid[1];
            end
            default: ;
        endcase
    end

    sad_pair_stage #(
        .SAD_W (SAD_W),
        .IDX_W (IDX_W)
    ) u_pair_stage (
        .a_sad   (a_sad),
        .a_index (a_index),
        .a_valid (a_valid),
        .b_sad   (b_sad),
        .b_index (b_index),
        .b_valid (b_valid),
        .w_sad   (w_sad),
        .w_index (w_index),
        .w_valid (w_valid)
    );

    // Beat capture, intermediate winners, running best and beat counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining  <= '0;
            lane_sad   <= '0;
            lane_index <= '0;
            lane_valid <= '0;
            win_sad    <= '0;
            win_index  <= '0;
            win_valid  <= '0;
            best_sad   <= '0;
            best_index <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        remaining  <= cfg_beats;
                        best_sad   <= '1;
                        best_index <= '0;
                    end
                end
                ST_WAIT: begin
                    if (in_valid) begin
                        lane_sad   <= in_sad;
                        lane_index <= in_index;
                        lane_valid <= beat_lane_valid;
                    end
                end
                ST_R1, ST_R2: begin
                    win_sad   <= w_sad;
                    win_index <= w_index;
                    win_valid <= w_valid;
                end
                ST_R3: begin
                    best_sad   <= w_sad[0];
                    best_index <= w_index[0];
                    if (remaining != '0) begin
                        remaining <= remaining - BEAT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sad_min_scheduler.sv
// Testbench for sad_min_scheduler: directed windows from the test plan plus
// randomized windows checked against a sequential minimum-search model.
// Honours SAD_LANE_MASK_EN when the design is built with the mask port.
module tb_sad_min_scheduler;
    import vbsme_pkg::*;

    localparam int SW   = 32;
    localparam int IW   = 32;
    localparam int BW   = 16;
    localparam int MAXB = 8;
`ifdef SAD_LANE_MASK_EN
    localparam bit MASK_ON = 1'b1;
`else
    localparam bit MASK_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [BW-1:0]     cfg_beats;
    logic              in_valid;
    logic              in_ready;
    logic [6*SW-1:0]   in_sad;
    logic [6*IW-1:0]   in_index;
`ifdef SAD_LANE_MASK_EN
    logic [5:0]        in_mask;
`endif
    logic              busy;
    logic              done;
    logic [SW-1:0]     best_sad;
    logic [IW-1:0]     best_index;

    logic [SW-1:0]     sad_tab  [MAXB][6];
    logic [IW-1:0]     idx_tab  [MAXB][6];
    logic [5:0]        mask_tab [MAXB];

    int  errors = 0;
    int  checks = 0;
    bit  eager_pending = 1'b0;

    sad_min_scheduler #(
        .SAD_W  (SW),
        .IDX_W  (IW),
        .BEAT_W (BW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cfg_beats  (cfg_beats),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sad     (in_sad),
        .in_index   (in_index),
`ifdef SAD_LANE_MASK_EN
        .in_mask    (in_mask),
`endif
        .busy       (busy),
        .done       (done),
        .best_sad   (best_sad),
        .best_index (best_index)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    function automatic bit laneMasked(input int b, input int l);
        return MASK_ON && (mask_tab[b][l] == 1'b1);
    endfunction

    // Reference: scan every candidate in arrival order, keep a strictly smaller one
    function automatic sad_cand_t modelWindow(input int n);
        sad_cand_t best;
        best.sad   = SAD_MAX;
        best.index = '0;
        for (int b = 0; b < n; b++) begin
            for (int l = 0; l < 6; l++) begin
                if (!laneMasked(b, l) && (sad_tab[b][l] < best.sad)) begin
                    best.sad   = sad_tab[b][l];
                    best.index = idx_tab[b][l];
                end
            end
        end
        return best;
    endfunction

    task automatic driveBeat(input int b);
        for (int l = 0; l < 6; l++) begin
            in_sad[l*SW +: SW]   = sad_tab[b][l];
            in_index[l*IW +: IW] = idx_tab[b][l];
        end
`ifdef SAD_LANE_MASK_EN
        in_mask = mask_tab[b];
`endif
    endtask

    // Present one beat, let it be accepted, and check the three busy cycles
    task automatic sendBeat(input int b, input bit more);
        int gap;
        if (!eager_pending) begin
            in_valid = 1'b0;
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                checkOutput("ready_wait", in_ready, 1);
                @(negedge clk);
            end
        end
        driveBeat(b);
        in_valid = 1'b1;
        checkOutput("ready_accept", in_ready, 1);
        checkOutput("done_accept", done, 0);
        @(negedge clk);
        eager_pending = more && ($urandom_range(0, 1) == 1);
        if (eager_pending) driveBeat(b + 1);
        else in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checkOutput("ready_low", in_ready, 0);
            checkOutput("done_low", done, 0);
            checkOutput("busy_mid", busy, 1);
            if (k == 0 && $urandom_range(0, 1) == 1) begin
                start     = 1'b1;
                cfg_beats = BW'($urandom_range(0, 5));
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    // Run one complete window of n beats from the tables and check the result
    task automatic runWindow(input int n);
        sad_cand_t exp;
        exp = modelWindow(n);
        eager_pending = 1'b0;
        in_valid  = 1'b0;
        start     = 1'b1;
        cfg_beats = BW'(n);
        @(negedge clk);
        start = 1'b0;
        checkOutput("busy_start", busy, 1);
        if (n == 0) begin
            checkOutput("ready_zero", in_ready, 0);
        end else begin
            checkOutput("done_start", done, 0);
            for (int b = 0; b < n; b++) sendBeat(b, b < n - 1);
        end
        checkOutput("done_pulse", done, 1);
        checkOutput("busy_done", busy, 1);
        checkOutput("best_sad", best_sad, exp.sad);
        checkOutput("best_index", best_index, exp.index);
        @(negedge clk);
        checkOutput("done_clear", done, 0);
        checkOutput("busy_clear", busy, 0);
        checkOutput("ready_idle", in_ready, 0);
        checkOutput("best_sad_hold", best_sad, exp.sad);
        checkOutput("best_index_hold", best_index, exp.index);
    endtask

    // Random window: small SADs to provoke ties, occasional all-ones lanes and masks
    task automatic applyStimulus(input int n);
        for (int b = 0; b < n; b++) begin
            for (int l = 0; l < 6; l++) begin
                sad_tab[b][l] = ($urandom_range(0, 9) == 0) ? SAD_MAX : SW'($urandom_range(0, 20));
                idx_tab[b][l] = $urandom;
            end
            mask_tab[b] = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'b0;
        end
        runWindow(n);
    endtask

    task automatic clearTables();
        for (int b = 0; b < MAXB; b++) begin
            for (int l = 0; l < 6; l++) begin
                sad_tab[b][l] = 100;
                idx_tab[b][l] = IW'(b * 6 + l);
            end
            mask_tab[b] = 6'b0;
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        cfg_beats = '0;
        in_valid  = 1'b0;
        in_sad    = '0;
        in_index  = '0;
`ifdef SAD_LANE_MASK_EN
        in_mask   = '0;
`endif
        clearTables();
        @(negedge clk);
        checkOutput("rst_ready", in_ready, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_best_sad", best_sad, 0);
        checkOutput("rst_best_index", best_index, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single beat, minimum at lane 4
        clearTables();
        sad_tab[0][0] = 50; sad_tab[0][1] = 40; sad_tab[0][2] = 30;
        sad_tab[0][3] = 20; sad_tab[0][4] = 10; sad_tab[0][5] = 60;
        runWindow(1);
        checkOutput("t1_sad", best_sad, 10);
        checkOutput("t1_index", best_index, 4);

        // Three beats, equal minima in beats 1 and 2: earlier beat wins
        clearTables();
        sad_tab[0][2] = 25;
        sad_tab[1][3] = 7;
        sad_tab[2][0] = 7;
        runWindow(3);
        checkOutput("t2_sad", best_sad, 7);
        checkOutput("t2_index", best_index, 9);

        // All lanes tie: lane 0 wins
        clearTables();
        for (int l = 0; l < 6; l++) begin
            sad_tab[0][l] = 9;
            idx_tab[0][l] = IW'(100 + l);
        end
        runWindow(1);
        checkOutput("t3_index", best_index, 100);

        // Empty window
        runWindow(0);
        checkOutput("t4_sad", best_sad, 32'hFFFF_FFFF);
        checkOutput("t4_index", best_index, 0);

        // Reset while beat 2 of 4 sits in R2
        for (int b = 0; b < 4; b++) begin
            for (int l = 0; l < 6; l++) begin
                sad_tab[b][l] = SW'($urandom_range(1, 50));
                idx_tab[b][l] = $urandom;
            end
            mask_tab[b] = 6'b0;
        end
        eager_pending = 1'b0;
        start = 1'b1;
        cfg_beats = 4;
        @(negedge clk);
        start = 1'b0;
        sendBeat(0, 1'b1);
        sendBeat(1, 1'b1);
        driveBeat(2);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_ready", in_ready, 0);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_done", done, 0);
        checkOutput("mid_rst_best_sad", best_sad, 0);
        checkOutput("mid_rst_best_index", best_index, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(1);

`ifdef SAD_LANE_MASK_EN
        clearTables();
        sad_tab[0][0] = 3; sad_tab[0][1] = 1;
        for (int l = 2; l < 6; l++) sad_tab[0][l] = 8;
        mask_tab[0] = 6'b000010;
        runWindow(1);
        checkOutput("mask_sad", best_sad, 3);
        checkOutput("mask_index", best_index, 0);
        mask_tab[0] = 6'b111111;
        runWindow(1);
        checkOutput("mask_all_sad", best_sad, 32'hFFFF_FFFF);
        checkOutput("mask_all_index", best_index, 0);
`endif

        // Randomized windows of varying length
        for (int w = 0; w < 24; w++) begin
            applyStimulus($urandom_range(0, MAXB));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
